// File: rtl/adc_packet_pkg.sv
// rtl/adc_packet_pkg.sv - packet format constants shared by the ADC packer, UART-side controller and host parser
// Optional overrun byte is selected with PACKER_OVERRUN_BYTE_EN.
package adc_packet_pkg;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam int unsigned DATA_BYTES     = 8;
  localparam int unsigned PKT_LEN_BASE   = 10;
  localparam int unsigned PKT_LEN_OVR    = 11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_OVR  = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_HDR  = S_HDR,
    ST_DATA = S_DATA,
    ST_OVR  = S_OVR,
    ST_CSUM = S_CSUM
  } pkt_state_t;

  // Samples are zero-padded to 16 bits, so the high byte already carries the leading zeros.
  function automatic logic [7:0] sample_byte(input logic [15:0] s, input logic lo);
    return lo ? s[7:0] : s[15:8];
  endfunction

endpackage

// File: rtl/adc_frame_stager.sv
// rtl/adc_frame_stager.sv - per-channel sample capture, latest-wins overwrite and frame-complete detection
module adc_frame_stager #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 10
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
  input  logic [NUM_CH-1:0]        i_ch_ready,
  output logic                     o_complete,
  output logic [NUM_CH*DATA_W-1:0] o_samples
);

  logic [NUM_CH*DATA_W-1:0] r_sample;
  logic [NUM_CH-1:0]        r_flags;
  logic                     w_complete;

  // Strobes in the completing cycle count towards the frame and feed the samples directly.
  assign w_complete = &(r_flags | i_ch_ready);
  assign o_complete = w_complete;

  always_comb begin
    o_samples = r_sample;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_ch_ready[k]) begin
        o_samples[k*DATA_W +: DATA_W] = i_ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_sample <= '0;
      r_flags  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_ch_ready[k]) begin
          r_sample[k*DATA_W +: DATA_W] <= i_ch_data[k*DATA_W +: DATA_W];
        end
      end
      r_flags <= w_complete ? '0 : (r_flags | i_ch_ready);
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// rtl/adc_frame_packer.sv - packs four ADC samples into header/data/checksum bytes for the UART TX
// Define PACKER_OVERRUN_BYTE_EN to insert the overrun-count byte before the checksum.
module adc_frame_packer
  import adc_packet_pkg::*;
#(
  parameter int          NUM_CH = 4,
  parameter int          DATA_W = 10,
  parameter logic [7:0]  HEADER = HEADER_DEFAULT,
  parameter int unsigned DECIM  = 1
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_ready,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic                     busy,
  output logic                     frame_drop
);

  localparam logic [15:0] DECIM_LAST = 16'(DECIM - 1);
  localparam logic [2:0]  LAST_IDX   = 3'(DATA_BYTES - 1);

  pkt_state_t               r_state;
  logic [7:0]               r_byte_out;
  logic                     r_byte_valid;
  logic [2:0]               r_idx;
  logic [7:0]               r_csum;
  logic [NUM_CH*DATA_W-1:0] r_shadow;
  logic [15:0]              r_decim_cnt;
  logic                     r_frame_drop;

  logic                     w_complete;
  logic [NUM_CH*DATA_W-1:0] w_samples;
  logic                     w_eligible;
  logic                     w_launch;
  logic                     w_drop;
  logic                     w_xfer;
  logic [2:0]               w_idx_nxt;
  logic [7:0]               w_csum_nxt;
  logic [15:0]              w_pad [NUM_CH];

  adc_frame_stager #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) u_stager (
    .clk        (clk),
    .reset_b    (reset_b),
    .i_ch_data  (ch_data),
    .i_ch_ready (ch_ready),
    .o_complete (w_complete),
    .o_samples  (w_samples)
  );

  assign w_eligible = w_complete && (r_decim_cnt == DECIM_LAST);
  assign w_launch   = w_eligible && (r_state == ST_IDLE);
  assign w_drop     = w_eligible && (r_state != ST_IDLE);
  assign w_xfer     = r_byte_valid && byte_ready;
  assign w_idx_nxt  = r_idx + 3'd1;
  assign w_csum_nxt = r_csum ^ r_byte_out;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_pad[c] = 16'(r_shadow[c*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_decim_cnt  <= '0;
      r_frame_drop <= 1'b0;
    end else begin
      r_frame_drop <= w_drop;
      if (w_complete) begin
        r_decim_cnt <= (r_decim_cnt == DECIM_LAST) ? '0 : r_decim_cnt + 16'd1;
      end
    end
  end

`ifdef PACKER_OVERRUN_BYTE_EN
  logic [7:0] r_ovr_cnt;

  // Clearing on the OVR transfer must not lose a drop landing in that very cycle.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_ovr_cnt <= '0;
    end else if (r_state == ST_OVR && w_xfer) begin
      r_ovr_cnt <= {7'd0, w_drop};
    end else if (w_drop && r_ovr_cnt != 8'hFF) begin
      r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state      <= ST_IDLE;
      r_byte_out   <= '0;
      r_byte_valid <= 1'b0;
      r_idx        <= '0;
      r_csum       <= '0;
      r_shadow     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_shadow     <= w_samples;
            r_state      <= ST_HDR;
            r_byte_out   <= HEADER;
            r_byte_valid <= 1'b1;
          end
        end
        ST_HDR: begin
          if (w_xfer) begin
            r_state    <= ST_DATA;
            r_idx      <= '0;
            r_csum     <= '0;
            r_byte_out <= sample_byte(w_pad[0], 1'b0);
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_csum <= w_csum_nxt;
            r_idx  <= w_idx_nxt;
            if (r_idx == LAST_IDX) begin
`ifdef PACKER_OVERRUN_BYTE_EN
              r_state    <= ST_OVR;
              r_byte_out <= r_ovr_cnt;
`else
              r_state    <= ST_CSUM;
              r_byte_out <= w_csum_nxt;
`endif
            end else begin
              r_byte_out <= sample_byte(w_pad[w_idx_nxt[2:1]], w_idx_nxt[0]);
            end
          end
        end
        ST_OVR: begin
          if (w_xfer) begin
            r_csum     <= w_csum_nxt;
            r_state    <= ST_CSUM;
            r_byte_out <= w_csum_nxt;
          end
        end
        ST_CSUM: begin
          if (w_xfer) begin
            r_state      <= ST_IDLE;
            r_byte_valid <= 1'b0;
            r_byte_out   <= '0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_byte_valid <= 1'b0;
        end
      endcase
    end
  end

  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign busy       = (r_state != ST_IDLE);
  assign frame_drop = r_frame_drop;

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb/tb_adc_frame_packer.sv - scoreboard bench for adc_frame_packer (default and DECIM=3 instances)
// Honours PACKER_OVERRUN_BYTE_EN when building expected packets.
module tb_adc_frame_packer;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [39:0] ch_data;
  logic [3:0]  ch_ready;
  logic [3:0]  ch_ready3;
  logic        byte_ready;
  logic [7:0]  byte_out, byte_out3;
  logic        byte_valid, byte_valid3;
  logic        busy, busy3;
  logic        frame_drop, frame_drop3;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int vcnt = 0;
  int drop_cnt = 0;
  int drop3_cnt = 0;
  int pkt3 = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic prev_busy3 = 1'b0;
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  adc_frame_packer dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .frame_drop (frame_drop)
  );

  adc_frame_packer #(.DECIM(3)) dut3 (
    .clk        (clk),
    .reset_b    (reset_b),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready3),
    .byte_out   (byte_out3),
    .byte_valid (byte_valid3),
    .byte_ready (byte_ready),
    .busy       (busy3),
    .frame_drop (frame_drop3)
  );

  function automatic logic [39:0] pack4(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c, input logic [9:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_packet(input logic [9:0] s0, input logic [9:0] s1,
                             input logic [9:0] s2, input logic [9:0] s3);
    logic [9:0] s [4];
    logic [7:0] b;
    logic [7:0] cs;
    s = '{s0, s1, s2, s3};
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int c = 0; c < 4; c++) begin
      b = {6'b000000, s[c][9:8]};
      exp_q.push_back(b);
      cs ^= b;
      b = s[c][7:0];
      exp_q.push_back(b);
      cs ^= b;
    end
`ifdef PACKER_OVERRUN_BYTE_EN
    exp_q.push_back(8'h00);
`endif
    exp_q.push_back(cs);
  endtask

  task automatic drive(input logic [3:0] rdy, input logic [39:0] data);
    @(posedge clk); #1;
    ch_ready = rdy;
    ch_data  = data;
    @(posedge clk); #1;
    ch_ready = 4'h0;
  endtask

  task automatic drive3(input logic [39:0] data);
    @(posedge clk); #1;
    ch_ready3 = 4'hF;
    ch_data   = data;
    @(posedge clk); #1;
    ch_ready3 = 4'h0;
  endtask

  task automatic send_serial(input logic [9:0] s0, input logic [9:0] s1,
                             input logic [9:0] s2, input logic [9:0] s3);
    push_packet(s0, s1, s2, s3);
    drive(4'h1, pack4(s0, s1, s2, s3));
    drive(4'h2, pack4(s0, s1, s2, s3));
    drive(4'h4, pack4(s0, s1, s2, s3));
    drive(4'h8, pack4(s0, s1, s2, s3));
  endtask

  task automatic check_header(input string tag);
    @(negedge clk);
    chk({tag, "_hdr_valid"}, int'(byte_valid), 1);
    chk({tag, "_hdr_byte"}, int'(byte_out), 'hA5);
  endtask

  task automatic wait_idle(input bit stall, input string tag);
    bit done;
    logic [3:0] pat;
    done = 1'b0;
    pat  = 4'b1001;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk); #1;
      byte_ready = stall ? pat[k % 4] : 1'b1;
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    byte_ready = 1'b1;
    checks++;
    assert (done === 1'b1) else begin
      failures++;
      $error("FAIL %s_timeout observed busy=%0b pending=%0d expected idle", tag, busy, exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (reset_b) begin
      if (byte_valid) vcnt++;
      if (frame_drop) drop_cnt++;
      if (frame_drop3) drop3_cnt++;
      if (busy3 && !prev_busy3) begin
        pkt3++;
        checks++;
        assert ({byte_valid3, byte_out3} === {1'b1, 8'hA5}) else begin
          failures++;
          $error("FAIL decim_hdr observed=%0h expected=1a5", {byte_valid3, byte_out3});
        end
      end
      if (prev_stall) begin
        checks++;
        assert ({byte_valid, byte_out} === {1'b1, prev_byte}) else begin
          failures++;
          $error("FAIL stall_hold observed=%0h expected=%0h", {byte_valid, byte_out}, {1'b1, prev_byte});
        end
      end
      if (byte_valid && byte_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_byte observed=%0h expected=none", byte_out);
        end
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          checks++;
          assert (byte_out === exp_b) else begin
            failures++;
            $error("FAIL packet_byte observed=%0h expected=%0h", byte_out, exp_b);
          end
        end
      end
      prev_stall = byte_valid && !byte_ready;
      prev_byte  = byte_out;
      prev_busy3 = busy3;
    end else begin
      prev_stall = 1'b0;
      prev_busy3 = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b    = 1'b0;
    ch_data    = '0;
    ch_ready   = 4'h0;
    ch_ready3  = 4'h0;
    byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_byte_out", int'(byte_out), 0);
    chk("rst_byte_valid", int'(byte_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_drop", int'(frame_drop), 0);
    @(posedge clk); #1;
    reset_b = 1'b1;

    // Basic packet, separate-cycle strobes, ready held high.
    vcnt = 0;
    send_serial(10'h3FF, 10'h155, 10'h0AA, 10'h001);
    check_header("t1");
    wait_idle(1'b0, "t1");
    chk("t1_valid_cycles", vcnt, 10);

    // Same frame with a stalling UART.
    send_serial(10'h3FF, 10'h155, 10'h0AA, 10'h001);
    check_header("t2");
    wait_idle(1'b1, "t2");

    // A frame completing mid-packet is dropped, packet in flight unchanged.
    drop_cnt = 0;
    send_serial(10'h123, 10'h2C4, 10'h05A, 10'h3E1);
    check_header("t3");
    repeat (3) @(posedge clk);
`ifdef PACKER_OVERRUN_BYTE_EN
    begin
      int n;
      n = exp_q.size();
      exp_q[n-1] = exp_q[n-1] ^ exp_q[n-2] ^ 8'h01;
      exp_q[n-2] = 8'h01;
    end
`endif
    drive(4'hF, pack4(10'h111, 10'h222, 10'h333, 10'h000));
    wait_idle(1'b0, "t3");
    chk("t3_drops", drop_cnt, 1);
    send_serial(10'h200, 10'h0FF, 10'h100, 10'h2AA);
    check_header("t3b");
    wait_idle(1'b0, "t3b");

    // Latest-wins overwrite on channel 0.
    push_packet(10'h020, 10'h0F0, 10'h30F, 10'h1C3);
    drive(4'h1, pack4(10'h010, 10'h000, 10'h000, 10'h000));
    drive(4'h1, pack4(10'h020, 10'h000, 10'h000, 10'h000));
    drive(4'h2, pack4(10'h020, 10'h0F0, 10'h000, 10'h000));
    drive(4'h4, pack4(10'h020, 10'h0F0, 10'h30F, 10'h000));
    drive(4'h8, pack4(10'h020, 10'h0F0, 10'h30F, 10'h1C3));
    check_header("t4");
    wait_idle(1'b0, "t4");

    // All four strobes in one cycle.
    push_packet(10'h2A5, 10'h15A, 10'h3C3, 10'h03C);
    drive(4'hF, pack4(10'h2A5, 10'h15A, 10'h3C3, 10'h03C));
    check_header("t5");
    wait_idle(1'b0, "t5");

    // DECIM=3 instance: six idle-spaced frames give two packets.
    pkt3 = 0;
    for (int f = 0; f < 6; f++) begin
      drive3(pack4(10'(f), 10'h001, 10'h002, 10'h003));
      if (f == 1) chk("decim_after_two", pkt3, 0);
      repeat (15) @(posedge clk);
    end
    chk("decim_packets", pkt3, 2);
    chk("decim_drops", drop3_cnt, 0);

    // Reset during DATA idx=4 aborts the packet.
    push_packet(10'h0C3, 10'h3A0, 10'h111, 10'h2EE);
    drive(4'hF, pack4(10'h0C3, 10'h3A0, 10'h111, 10'h2EE));
    check_header("t6");
    repeat (5) @(posedge clk);
    #1;
    reset_b = 1'b0;
    #1;
    chk("t6_abort_valid", int'(byte_valid), 0);
    chk("t6_abort_busy", int'(busy), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b1;
    @(negedge clk);
    chk("t6_idle_valid", int'(byte_valid), 0);
    chk("t6_idle_busy", int'(busy), 0);
    chk("t6_idle_byte", int'(byte_out), 0);
    send_serial(10'h3FF, 10'h000, 10'h2B4, 10'h0C9);
    check_header("t6b");
    wait_idle(1'b0, "t6b");
    chk("total_drops", drop_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
